// File: rtl/ex_wb_stage_pkg.sv
// Shared types and constants for the EX/WB pipeline stage.
// Holds the writeback state encoding and a register-address helper.
package ex_wb_stage_pkg;

  localparam int RF_ADDR_W = 5;
  localparam int XLEN      = 32;

  typedef enum logic [1:0] {
    WB_IDLE      = 2'd0,
    WB_WRITE     = 2'd1,
    WB_LOAD_WAIT = 2'd2
  } wb_state_e;

  function automatic logic is_x0(input logic [RF_ADDR_W-1:0] addr);
    return addr == '0;
  endfunction

endpackage

// File: rtl/wb_retire_counter.sv
// Wrapping retired-instruction counter: +1 per enabled cycle, rolls over
// from all-ones to zero with no saturation.
module wb_retire_counter #(
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             i_en,
  output logic [Width-1:0] o_cnt
);

  logic [Width-1:0] r_cnt;

  // NOTE: sequential state is written with <= only so every flop samples
  // the pre-edge values of its inputs, independent of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + Width'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/ex_wb_stage.sv
// Single-entry EX->WB pipeline register: holds one ALU/CSR result or one
// outstanding load, drives the register-file write port and ID forwarding.
module ex_wb_stage
  import ex_wb_stage_pkg::*;
#(
  parameter int unsigned RetireCntWidth = 32,
  parameter bit          SuppressX0     = 1'b1
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      ex_valid_i,
  input  logic                      ex_is_load_i,
  input  logic [RF_ADDR_W-1:0]      rf_waddr_ex_i,
  input  logic [XLEN-1:0]           rf_wdata_ex_i,
  input  logic                      rf_we_ex_i,
  input  logic                      lsu_resp_valid_i,
  input  logic [XLEN-1:0]           lsu_rdata_i,
  input  logic                      lsu_load_err_i,
  output logic                      wb_ready_o,
  output logic [RF_ADDR_W-1:0]      rf_waddr_o,
  output logic [XLEN-1:0]           rf_wdata_o,
  output logic                      rf_we_o,
  output logic                      fwd_valid_o,
  output logic                      fwd_pending_o,
  output logic                      load_err_o,
  output logic                      instr_retired_o,
  output logic [RetireCntWidth-1:0] retire_cnt_o
);

  wb_state_e            r_state;
  wb_state_e            w_state_nxt;
  logic [RF_ADDR_W-1:0] r_waddr;
  logic [XLEN-1:0]      r_wdata;
  logic                 r_we;

  logic w_in_write;
  logic w_in_load;
  logic w_resp;
  logic w_resp_ok;
  logic w_accept;
  logic w_we_allowed;
  logic w_retire;

  assign w_in_write = (r_state == WB_WRITE);
  assign w_in_load  = (r_state == WB_LOAD_WAIT);

  // A response only means something while a load is actually outstanding.
  assign w_resp    = w_in_load & lsu_resp_valid_i;
  assign w_resp_ok = w_resp & ~lsu_load_err_i;

  // The completing load frees the entry in the same edge a new result lands.
  assign wb_ready_o = ~w_in_load | lsu_resp_valid_i;
  assign w_accept   = ex_valid_i & wb_ready_o;

  always_comb begin
    // NOTE: default assignment first so every path drives the signal and
    // no latch is inferred.
    w_state_nxt = WB_IDLE;
    if (w_accept) begin
      w_state_nxt = ex_is_load_i ? WB_LOAD_WAIT : WB_WRITE;
    end else if (w_in_load && !lsu_resp_valid_i) begin
      w_state_nxt = WB_LOAD_WAIT;
    end
  end

  // NOTE: the payload registers are reset as well, so rf_waddr_o and
  // rf_wdata_o show known zeros straight out of reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= WB_IDLE;
      r_waddr <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_waddr <= rf_waddr_ex_i;
        r_we    <= rf_we_ex_i;
        // Load data arrives later from the LSU and bypasses this register.
        if (!ex_is_load_i) begin
          r_wdata <= rf_wdata_ex_i;
        end
      end
    end
  end

  assign w_we_allowed = r_we & ~(SuppressX0 & is_x0(r_waddr));
  assign w_retire     = w_in_write | w_resp_ok;

  assign rf_waddr_o      = r_waddr;
  assign rf_wdata_o      = w_resp ? lsu_rdata_i : r_wdata;
  assign rf_we_o         = w_we_allowed & (w_in_write | w_resp_ok);
  assign fwd_valid_o     = rf_we_o;
  assign fwd_pending_o   = w_in_load & r_we & ~is_x0(r_waddr);
  assign load_err_o      = w_resp & lsu_load_err_i;
  assign instr_retired_o = w_retire;

  wb_retire_counter #(
    .Width (RetireCntWidth)
  ) u_retire_counter (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .i_en   (w_retire),
    .o_cnt  (retire_cnt_o)
  );

endmodule

// File: tb/tb_ex_wb_stage.sv
// Bench for ex_wb_stage: hand-derived vector table for the directed cases,
// then a reset-during-load sequence and random traffic against a model.
module tb_ex_wb_stage;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        ex_valid_i, ex_is_load_i, rf_we_ex_i;
  logic [4:0]  rf_waddr_ex_i;
  logic [31:0] rf_wdata_ex_i;
  logic        lsu_resp_valid_i, lsu_load_err_i;
  logic [31:0] lsu_rdata_i;

  logic        wb_ready_o, rf_we_o, fwd_valid_o, fwd_pending_o, load_err_o, instr_retired_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o, retire_cnt_o;

  logic        n_ready, n_we, n_fwd, n_pend, n_err, n_ret;
  logic [4:0]  n_waddr;
  logic [31:0] n_wdata;
  logic [2:0]  n_cnt;

  always #5 clk_i = ~clk_i;

  ex_wb_stage dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .ex_valid_i(ex_valid_i), .ex_is_load_i(ex_is_load_i),
    .rf_waddr_ex_i(rf_waddr_ex_i), .rf_wdata_ex_i(rf_wdata_ex_i), .rf_we_ex_i(rf_we_ex_i),
    .lsu_resp_valid_i(lsu_resp_valid_i), .lsu_rdata_i(lsu_rdata_i), .lsu_load_err_i(lsu_load_err_i),
    .wb_ready_o(wb_ready_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o), .rf_we_o(rf_we_o),
    .fwd_valid_o(fwd_valid_o), .fwd_pending_o(fwd_pending_o), .load_err_o(load_err_o),
    .instr_retired_o(instr_retired_o), .retire_cnt_o(retire_cnt_o)
  );

  // Narrow counter that wraps quickly and writes x0 like any other register.
  ex_wb_stage #(.RetireCntWidth(3), .SuppressX0(1'b0)) dut_n (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .ex_valid_i(ex_valid_i), .ex_is_load_i(ex_is_load_i),
    .rf_waddr_ex_i(rf_waddr_ex_i), .rf_wdata_ex_i(rf_wdata_ex_i), .rf_we_ex_i(rf_we_ex_i),
    .lsu_resp_valid_i(lsu_resp_valid_i), .lsu_rdata_i(lsu_rdata_i), .lsu_load_err_i(lsu_load_err_i),
    .wb_ready_o(n_ready), .rf_waddr_o(n_waddr), .rf_wdata_o(n_wdata), .rf_we_o(n_we),
    .fwd_valid_o(n_fwd), .fwd_pending_o(n_pend), .load_err_o(n_err),
    .instr_retired_o(n_ret), .retire_cnt_o(n_cnt)
  );

  typedef struct {
    logic        ex_valid, is_load;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        we, resp;
    logic [31:0] rdata;
    logic        err;
    logic        e_we;
    logic [4:0]  e_waddr;
    logic [31:0] e_wdata;
    logic        e_ready, e_pend, e_err, e_ret;
    logic [31:0] e_cnt;
  } vec_t;

  int total = 0;
  int bad   = 0;

  // Model: what the single slot currently holds, described in plain terms.
  localparam int K_NONE = 0, K_ALU = 1, K_LOAD = 2;
  int          m_kind;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  logic        m_we;
  longint      m_retired;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_kind = K_NONE; m_addr = '0; m_data = '0; m_we = 1'b0; m_retired = 0;
  endtask

  function automatic vec_t mk(input logic exv, input logic ld, input logic [4:0] wa,
                              input logic [31:0] wd, input logic we, input logic rv,
                              input logic [31:0] rd, input logic er, input logic e_we,
                              input logic [4:0] e_wa, input logic [31:0] e_wd, input logic e_rdy,
                              input logic e_pd, input logic e_er, input logic e_rt,
                              input logic [31:0] e_ct);
    vec_t v;
    v.ex_valid = exv; v.is_load = ld; v.waddr = wa; v.wdata = wd; v.we = we;
    v.resp = rv; v.rdata = rd; v.err = er;
    v.e_we = e_we; v.e_waddr = e_wa; v.e_wdata = e_wd; v.e_ready = e_rdy;
    v.e_pend = e_pd; v.e_err = e_er; v.e_ret = e_rt; v.e_cnt = e_ct;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    ex_valid_i = v.ex_valid; ex_is_load_i = v.is_load; rf_waddr_ex_i = v.waddr;
    rf_wdata_ex_i = v.wdata; rf_we_ex_i = v.we; lsu_resp_valid_i = v.resp;
    lsu_rdata_i = v.rdata; lsu_load_err_i = v.err;
  endtask

  // One clock: drive at negedge, compare 1ns later, advance the model at posedge.
  task automatic run_cycle(input vec_t v, input bit use_table, input string tag);
    logic resp, ready, ret, wr;
    @(negedge clk_i);
    drive(v);
    #1;
    resp  = (m_kind == K_LOAD) && v.resp;
    ready = (m_kind != K_LOAD) || v.resp;
    ret   = (m_kind == K_ALU) || (resp && !v.err);
    wr    = ret && m_we;
    if (use_table) begin
      check({tag, " rf_we"},    32'(rf_we_o),         32'(v.e_we));
      check({tag, " waddr"},    32'(rf_waddr_o),      32'(v.e_waddr));
      check({tag, " wdata"},    rf_wdata_o,           v.e_wdata);
      check({tag, " fwd"},      32'(fwd_valid_o),     32'(v.e_we));
      check({tag, " ready"},    32'(wb_ready_o),      32'(v.e_ready));
      check({tag, " pending"},  32'(fwd_pending_o),   32'(v.e_pend));
      check({tag, " load_err"}, 32'(load_err_o),      32'(v.e_err));
      check({tag, " retired"},  32'(instr_retired_o), 32'(v.e_ret));
      check({tag, " cnt"},      retire_cnt_o,         v.e_cnt);
    end else begin
      check({tag, " rf_we"},    32'(rf_we_o),         32'(wr && (m_addr != 0)));
      check({tag, " waddr"},    32'(rf_waddr_o),      32'(m_addr));
      check({tag, " wdata"},    rf_wdata_o,           resp ? v.rdata : m_data);
      check({tag, " fwd"},      32'(fwd_valid_o),     32'(wr && (m_addr != 0)));
      check({tag, " ready"},    32'(wb_ready_o),      32'(ready));
      check({tag, " pending"},  32'(fwd_pending_o),   32'((m_kind == K_LOAD) && m_we && (m_addr != 0)));
      check({tag, " load_err"}, 32'(load_err_o),      32'(resp && v.err));
      check({tag, " retired"},  32'(instr_retired_o), 32'(ret));
      check({tag, " cnt"},      retire_cnt_o,         32'(m_retired % 64'h1_0000_0000));
      check({tag, " x0 rf_we"}, 32'(n_we),            32'(wr));
      check({tag, " cnt3"},     32'(n_cnt),           32'(m_retired % 8));
    end
    @(posedge clk_i);
    if (ret) m_retired++;
    if (v.ex_valid && ready) begin
      m_kind = v.is_load ? K_LOAD : K_ALU;
      m_addr = v.waddr;
      m_we   = v.we;
      if (!v.is_load) m_data = v.wdata;
    end else if (!(m_kind == K_LOAD && !v.resp)) begin
      m_kind = K_NONE;
    end
  endtask

  vec_t vecs[$];
  vec_t idle_v, v;

  initial begin
    idle_v = mk(0,0,0,0,0,0,0,0, 0,0,0,1,0,0,0,0);
    drive(idle_v);
    model_reset();
    #12;
    check("reset ready", 32'(wb_ready_o), 32'd1);
    check("reset rf_we", 32'(rf_we_o), 32'd0);
    check("reset cnt",   retire_cnt_o, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    //           ex ld wa    wd            we rv rd            er | we wa   wd            rdy pd er rt cnt
    vecs.push_back(mk(0,0,0,  32'h0,        0,0,32'h0,        0,   0,0,  32'h0,        1,0,0,0,0));
    vecs.push_back(mk(1,0,5,  32'hDEADBEEF, 1,0,32'h0,        0,   0,0,  32'h0,        1,0,0,0,0));
    vecs.push_back(mk(0,0,0,  32'h0,        0,0,32'h0,        0,   1,5,  32'hDEADBEEF, 1,0,0,1,0));
    vecs.push_back(mk(1,0,0,  32'h1234,     1,0,32'h0,        0,   0,5,  32'hDEADBEEF, 1,0,0,0,1));
    vecs.push_back(mk(0,0,0,  32'h0,        0,0,32'h0,        0,   0,0,  32'h1234,     1,0,0,1,1));
    vecs.push_back(mk(1,1,7,  32'hAAAA,     1,0,32'h0,        0,   0,0,  32'h1234,     1,0,0,0,2));
    vecs.push_back(mk(0,0,0,  32'h0,        0,0,32'h0,        0,   0,7,  32'h1234,     0,1,0,0,2));
    vecs.push_back(mk(1,0,3,  32'h77,       1,0,32'h0,        0,   0,7,  32'h1234,     0,1,0,0,2));
    vecs.push_back(mk(0,0,0,  32'h0,        0,0,32'h0,        0,   0,7,  32'h1234,     0,1,0,0,2));
    vecs.push_back(mk(0,0,0,  32'h0,        0,1,32'hCAFEF00D, 0,   1,7,  32'hCAFEF00D, 1,1,0,1,2));
    vecs.push_back(mk(0,0,0,  32'h0,        0,0,32'h0,        0,   0,7,  32'h1234,     1,0,0,0,3));
    vecs.push_back(mk(1,1,8,  32'h0,        1,0,32'h0,        0,   0,7,  32'h1234,     1,0,0,0,3));
    vecs.push_back(mk(1,0,9,  32'h55,       1,1,32'h11112222, 0,   1,8,  32'h11112222, 1,1,0,1,3));
    vecs.push_back(mk(0,0,0,  32'h0,        0,0,32'h0,        0,   1,9,  32'h55,       1,0,0,1,4));
    vecs.push_back(mk(1,1,10, 32'h0,        1,0,32'h0,        0,   0,9,  32'h55,       1,0,0,0,5));
    vecs.push_back(mk(0,0,0,  32'h0,        0,0,32'h0,        0,   0,10, 32'h55,       0,1,0,0,5));
    vecs.push_back(mk(0,0,0,  32'h0,        0,1,32'hBAD,      1,   0,10, 32'hBAD,      1,1,1,0,5));
    vecs.push_back(mk(0,0,0,  32'h0,        0,0,32'h0,        0,   0,10, 32'h55,       1,0,0,0,5));
    vecs.push_back(mk(0,0,0,  32'h0,        0,1,32'h999,      0,   0,10, 32'h55,       1,0,0,0,5));
    vecs.push_back(mk(0,0,0,  32'h0,        0,0,32'h0,        0,   0,10, 32'h55,       1,0,0,0,5));
    foreach (vecs[i]) run_cycle(vecs[i], 1'b1, $sformatf("vec%0d", i));

    // Reset while a load is outstanding: the load must vanish without a write.
    run_cycle(mk(1,1,12,32'h0,1,0,32'h0,0, 0,0,0,0,0,0,0,0), 1'b0, "rst_accept");
    @(negedge clk_i);
    drive(idle_v);
    #1;
    check("rst pending before", 32'(fwd_pending_o), 32'd1);
    #2;
    rst_ni = 1'b0;
    #1;
    model_reset();
    check("rst ready",   32'(wb_ready_o),    32'd1);
    check("rst pending", 32'(fwd_pending_o), 32'd0);
    check("rst rf_we",   32'(rf_we_o),       32'd0);
    check("rst cnt",     retire_cnt_o,       32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    run_cycle(mk(0,0,0,32'h0,0,1,32'h5A5A5A5A,0, 0,0,0,0,0,0,0,0), 1'b0, "stray");
    run_cycle(idle_v, 1'b0, "post_stray");

    for (int i = 0; i < 400; i++) begin
      v = idle_v;
      v.ex_valid = ($urandom_range(0, 99) < 55);
      v.is_load  = ($urandom_range(0, 99) < 35);
      v.waddr    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      v.wdata    = $urandom;
      v.we       = ($urandom_range(0, 9) != 0);
      v.resp     = ($urandom_range(0, 99) < 40);
      v.rdata    = $urandom;
      v.err      = ($urandom_range(0, 99) < 15);
      run_cycle(v, 1'b0, $sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
